uart_frame_assembler: RTL and testbench

- Sits directly downstream of uart_receive and consumes its new_data_out / data_byte_out strobe pair.
- Parses framed packets from the host: header 0xA5, length byte N (in words), N×4 payload bytes (little-endian), then an XOR checksum byte.
- Emits assembled 32-bit words with a frame-relative word address, intended for a BRAM write port.
- Reports frame completion or error so the host-load path can commit or discard the frame.

---
 rtl/uart_frame_assembler_pkg.sv | 20 ++
 rtl/uart_frame_assembler_timeout.sv | 38 +++
 rtl/uart_frame_assembler.sv | 175 +++++++++++++++++
 tb/tb_uart_frame_assembler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_assembler_pkg.sv
// Shared types for the UART host-load frame path: parser states and error codes.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_LEN     = 2'd3
  } err_code_e;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_assembler_timeout.sv
// Inter-byte idle watchdog: counts enabled cycles since the last clear and flags expiry.
module byte_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic enable_in,
  output logic expired_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A clear in the expiry cycle wins, so a byte arriving right at the limit is never lost.
  assign expired_out = enable_in && !clear_in && (count_q == LAST_CNT);

  always_comb begin
    count_d = count_q;
    if (clear_in || !enable_in) begin
      count_d = '0;
    end else if (count_q != LAST_CNT) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Parses A5/len/payload/xor-checksum frames from uart_receive into addressed 32-bit words.
module uart_frame_assembler
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  HEADER_BYTE    = DEFAULT_HEADER_BYTE,
  parameter int unsigned MAX_WORDS      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100_000,
  parameter int unsigned ADDR_WIDTH     = $clog2(MAX_WORDS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  byte_valid_in,
  input  logic [7:0]            byte_in,
  output logic [31:0]           word_out,
  output logic                  word_valid_out,
  output logic [ADDR_WIDTH-1:0] word_addr_out,
  output logic [7:0]            frame_len_out,
  output logic                  frame_done_out,
  output logic                  frame_err_out,
  output logic [1:0]            err_code_out,
  output logic                  busy_out
);

  state_e                state_q, state_d;
  err_code_e             err_code_q, err_code_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [7:0]            checksum_q, checksum_d;
  logic [23:0]           word_acc_q, word_acc_d;
  logic [7:0]            frame_len_q, frame_len_d;
  logic [31:0]           word_out_q, word_out_d;
  logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic                  word_valid_q, word_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;
  logic                  timeout_expired;
  logic                  len_bad;
  logic                  last_word;

  byte_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear_in   (byte_valid_in),
    .enable_in  (state_q != IDLE),
    .expired_out(timeout_expired)
  );

  assign len_bad   = (byte_in == 8'd0) || (32'(byte_in) > MAX_WORDS);
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(frame_len_q);

  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    byte_cnt_d   = byte_cnt_q;
    word_idx_d   = word_idx_q;
    checksum_d   = checksum_q;
    word_acc_d   = word_acc_q;
    frame_len_d  = frame_len_q;
    word_out_d   = word_out_q;
    word_addr_d  = word_addr_q;
    word_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (byte_valid_in && byte_in == HEADER_BYTE) begin
          state_d    = LEN;
          err_code_d = ERR_NONE;
          checksum_d = 8'd0;
        end
      end
      LEN: begin
        if (byte_valid_in) begin
          if (len_bad) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = IDLE;
          end else begin
            frame_len_d = byte_in;
            byte_cnt_d  = 2'd0;
            word_idx_d  = '0;
            state_d     = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_valid_in) begin
          checksum_d = checksum_q ^ byte_in;
          byte_cnt_d = byte_cnt_q + 2'd1;
          unique case (byte_cnt_q)
            2'd0: word_acc_d[7:0]   = byte_in;
            2'd1: word_acc_d[15:8]  = byte_in;
            2'd2: word_acc_d[23:16] = byte_in;
            default: begin
              // Words are released before the checksum; the consumer commits on frame_done.
              word_out_d   = {byte_in, word_acc_q};
              word_addr_d  = word_idx_q;
              word_valid_d = 1'b1;
              word_idx_d   = word_idx_q + ADDR_WIDTH'(1);
              if (last_word) begin
                state_d = CHECK;
              end
            end
          endcase
        end
      end
      CHECK: begin
        if (byte_valid_in) begin
          if (byte_in == checksum_q) begin
            frame_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_expired) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = IDLE;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      err_code_q   <= ERR_NONE;
      byte_cnt_q   <= 2'd0;
      word_idx_q   <= '0;
      checksum_q   <= 8'd0;
      word_acc_q   <= 24'd0;
      frame_len_q  <= 8'd0;
      word_out_q   <= 32'd0;
      word_addr_q  <= '0;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      byte_cnt_q   <= byte_cnt_d;
      word_idx_q   <= word_idx_d;
      checksum_q   <= checksum_d;
      word_acc_q   <= word_acc_d;
      frame_len_q  <= frame_len_d;
      word_out_q   <= word_out_d;
      word_addr_q  <= word_addr_d;
      word_valid_q <= word_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign word_out       = word_out_q;
  assign word_valid_out = word_valid_q;
  assign word_addr_out  = word_addr_q;
  assign frame_len_out  = frame_len_q;
  assign frame_done_out = frame_done_q;
  assign frame_err_out  = frame_err_q;
  assign err_code_out   = err_code_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Self-checking bench for uart_frame_assembler against a frame-level reference model.
module tb_uart_frame_assembler;

  localparam int TMO  = 1000;
  localparam int MAXW = 64;
  localparam int AW   = 6;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          byte_valid_in = 1'b0;
  logic [7:0]    byte_in = 8'd0;
  logic [31:0]   word_out;
  logic          word_valid_out;
  logic [AW-1:0] word_addr_out;
  logic [7:0]    frame_len_out;
  logic          frame_done_out;
  logic          frame_err_out;
  logic [1:0]    err_code_out;
  logic          busy_out;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state: bytes of the frame in progress (length byte first).
  bit            m_in_frame = 1'b0;
  logic [7:0]    m_q[$];
  int            m_gap = 0;
  logic [31:0]   m_word = 32'd0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_len = 8'd0;
  logic [1:0]    m_code = 2'd0;
  bit            m_wv = 1'b0;
  bit            m_done = 1'b0;
  bit            m_err = 1'b0;

  logic [7:0]    seq[$];

  always #5 clk_in = ~clk_in;

  uart_frame_assembler #(
    .HEADER_BYTE   (8'hA5),
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TMO),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .byte_valid_in (byte_valid_in),
    .byte_in       (byte_in),
    .word_out      (word_out),
    .word_valid_out(word_valid_out),
    .word_addr_out (word_addr_out),
    .frame_len_out (frame_len_out),
    .frame_done_out(frame_done_out),
    .frame_err_out (frame_err_out),
    .err_code_out  (err_code_out),
    .busy_out      (busy_out)
  );

  function automatic void mdlReset();
    m_in_frame = 1'b0;
    m_q.delete();
    m_gap  = 0;
    m_word = 32'd0;
    m_addr = '0;
    m_len  = 8'd0;
    m_code = 2'd0;
    m_wv   = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endfunction

  function automatic void mdlByte(input logic [7:0] b);
    int n;
    int pc;
    logic [7:0] cs;
    m_wv   = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_gap  = 0;
    if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1'b1;
        m_q.delete();
        m_code = 2'd0;
      end
    end else begin
      m_q.push_back(b);
      n = int'(m_q[0]);
      if (m_q.size() == 1) begin
        if (n == 0 || n > MAXW) begin
          m_err = 1'b1;
          m_code = 2'd3;
          m_in_frame = 1'b0;
        end else begin
          m_len = b;
        end
      end else if (m_q.size() <= 4 * n + 1) begin
        pc = m_q.size() - 1;
        if (pc % 4 == 0) begin
          m_wv   = 1'b1;
          m_addr = AW'(pc / 4 - 1);
          m_word = {m_q[pc], m_q[pc-1], m_q[pc-2], m_q[pc-3]};
        end
      end else begin
        cs = 8'd0;
        for (int i = 1; i <= 4 * n; i++) cs = cs ^ m_q[i];
        if (b == cs) begin
          m_done = 1'b1;
        end else begin
          m_err = 1'b1;
          m_code = 2'd1;
        end
        m_in_frame = 1'b0;
      end
    end
  endfunction

  function automatic void mdlIdle();
    m_wv   = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_in_frame) begin
      m_gap++;
      if (m_gap == TMO) begin
        m_err = 1'b1;
        m_code = 2'd2;
        m_in_frame = 1'b0;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " word_valid"}, 32'(word_valid_out), 32'(m_wv));
    checkOutput({tag, " word_out"},   word_out,               m_word);
    checkOutput({tag, " word_addr"},  32'(word_addr_out),  32'(m_addr));
    checkOutput({tag, " frame_len"},  32'(frame_len_out),  32'(m_len));
    checkOutput({tag, " frame_done"}, 32'(frame_done_out), 32'(m_done));
    checkOutput({tag, " frame_err"},  32'(frame_err_out),  32'(m_err));
    checkOutput({tag, " err_code"},   32'(err_code_out),   32'(m_code));
    checkOutput({tag, " busy"},       32'(busy_out),       32'(m_in_frame));
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk_in);
    byte_valid_in = 1'b1;
    byte_in = b;
    @(posedge clk_in);
    #1;
    mdlByte(b);
    checkAll("byte");
  endtask

  task automatic idleCycles(input int n);
    byte_valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      mdlIdle();
      checkAll("idle");
    end
  endtask

  task automatic resetDut();
    @(negedge clk_in);
    rst_in = 1'b0;
    byte_valid_in = 1'b0;
    @(posedge clk_in);
    #1;
    mdlReset();
    checkAll("reset");
    rst_in = 1'b1;
  endtask

  task automatic sendSeq(input int max_gap);
    foreach (seq[i]) begin
      applyStimulus(seq[i]);
      idleCycles(int'($urandom_range(0, max_gap)));
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] n;
    logic [7:0] cs;
    int kind;

    resetDut();

    // Garbage before the header, then a single-word good frame.
    seq = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    sendSeq(2);
    idleCycles(2);
    checkOutput("tp_good_word", word_out, 32'h44332211);
    checkOutput("tp_good_code", 32'(err_code_out), 32'd0);

    seq = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
    sendSeq(1);
    idleCycles(2);
    checkOutput("tp_two_word", word_out, 32'h00000002);
    checkOutput("tp_two_addr", 32'(word_addr_out), 32'd1);

    seq = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    sendSeq(1);
    idleCycles(2);
    checkOutput("tp_csum_code", 32'(err_code_out), 32'd1);

    seq = '{8'hA5, 8'h00};
    sendSeq(1);
    checkOutput("tp_len0_code", 32'(err_code_out), 32'd3);
    seq = '{8'hA5, 8'h41};
    sendSeq(1);
    checkOutput("tp_len65_code", 32'(err_code_out), 32'd3);

    // Largest legal frame, all bytes back-to-back.
    seq = '{8'hA5, 8'h40};
    cs = 8'd0;
    for (int i = 0; i < 4 * MAXW; i++) begin
      b = 8'($urandom);
      cs = cs ^ b;
      seq.push_back(b);
    end
    seq.push_back(cs);
    sendSeq(0);
    idleCycles(2);
    checkOutput("tp_max_addr", 32'(word_addr_out), 32'd63);

    seq = '{8'hA5, 8'h01, 8'h11};
    sendSeq(0);
    idleCycles(TMO + 5);
    checkOutput("tp_tmo_code", 32'(err_code_out), 32'd2);
    checkOutput("tp_tmo_busy", 32'(busy_out), 32'd0);
    seq = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    sendSeq(1);

    // Byte lands on the expiry cycle: it must be taken and the frame completes.
    seq = '{8'hA5, 8'h01, 8'h11};
    sendSeq(0);
    idleCycles(TMO - 1);
    seq = '{8'h22, 8'h33, 8'h44, 8'h44};
    sendSeq(0);
    idleCycles(1);
    checkOutput("tp_race_code", 32'(err_code_out), 32'd0);

    seq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03};
    sendSeq(1);
    resetDut();
    idleCycles(3);
    seq = '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    sendSeq(1);

    for (int f = 0; f < 30; f++) begin
      seq.delete();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        seq.push_back(b);
      end
      seq.push_back(8'hA5);
      kind = int'($urandom_range(0, 9));
      if (kind == 0) n = 8'd0;
      else if (kind == 1) n = 8'(65 + $urandom_range(0, 190));
      else n = 8'($urandom_range(1, 6));
      seq.push_back(n);
      if (n >= 8'd1 && n <= 8'd64) begin
        cs = 8'd0;
        for (int i = 0; i < 4 * int'(n); i++) begin
          b = 8'($urandom);
          cs = cs ^ b;
          seq.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
        seq.push_back(cs);
      end
      sendSeq(2);
    end
    idleCycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
